// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
//
// The fetch stage presents a byte address. The cache returns the aligned 64-bit
// doubleword that contains it. On a miss, the cache refills one whole line over
// a burst read port and then delivers the requested word from the refill.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cache_req/addr_inst fetch request (handshake with cache_ready)
//   cache_ready         request can be accepted this cycle
//   cache_valid         one-cycle response pulse, data on inst_data
//   flush               invalidate all lines (fence.i)
//   mem_req/mem_addr    line-aligned refill request (handshake with mem_ready)
//   mem_rvalid/rdata    refill beats in ascending address order
//   mem_rlast           last beat of the refill burst
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 6,
    parameter int LINE_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_req,
    input  logic [ADDR_W-1:0] addr_inst,
    output logic              cache_ready,
    output logic              cache_valid,
    output logic [63:0]       inst_data,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rlast
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int WORDS = LINE_BYTES / 8;
    localparam int CNT_W = $clog2(WORDS);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int DW_W  = ADDR_W - 3;   // doubleword address width

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [DW_W-1:0]        addr_q, addr_d;   // doubleword address of the request
    logic [CNT_W-1:0]       cnt_q, cnt_d;     // refill beat counter
    logic                   pend_q, pend_d;   // flush arrived during a miss
    logic [63:0]            resp_q, resp_d;   // word captured during refill
    logic [LINES-1:0]       valid_q, valid_d;

    logic [63:0]            data_q [LINES*WORDS];
    logic [TAG_W-1:0]       tag_q  [LINES];

    logic [INDEX_W-1:0]     idx;
    logic [TAG_W-1:0]       tag;
    logic [CNT_W-1:0]       woff;
    logic                   hit;
    logic                   data_we;
    logic                   tag_we;

    // The byte offset inside a doubleword is not needed; the fetch stage picks the half.
    logic                   unused_lo;
    assign unused_lo = ^addr_inst[2:0];

    // addr_q drops the low 3 bits, so its low CNT_W bits are the word offset in the line.
    assign woff = addr_q[CNT_W-1:0];
    assign idx  = addr_q[CNT_W +: INDEX_W];
    assign tag  = addr_q[DW_W-1 -: TAG_W];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    assign mem_req  = (state_q == S_MISS_REQ) && !rst;
    assign mem_addr = mem_req ? {addr_q[DW_W-1:CNT_W], {OFF_W{1'b0}}} : '0;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        resp_d      = resp_q;
        valid_d     = valid_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        cache_ready = 1'b0;
        cache_valid = 1'b0;
        inst_data   = '0;

        case (state_q)
            S_IDLE: begin
                cache_ready = 1'b1;
                if (flush) valid_d = '0;
                if (cache_req) begin
                    addr_d  = addr_inst[ADDR_W-1:3];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // The hit decision uses valid_q, so a flush in this cycle only affects later lookups.
                if (flush) valid_d = '0;
                if (hit) begin
                    cache_valid = 1'b1;
                    inst_data   = data_q[{idx, woff}];
                    cache_ready = 1'b1;
                    if (cache_req) addr_d = addr_inst[ADDR_W-1:3];
                    else           state_d = S_IDLE;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == woff) resp_d = mem_rdata;
                    if (mem_rlast) begin
                        // A short burst still validates the line; the protocol rules it out.
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        cnt_d        = '0;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                cache_valid = 1'b1;
                inst_data   = resp_q;
                state_d     = S_IDLE;
                if (pend_q || flush) begin
                    valid_d = '0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush && (state_q == S_MISS_REQ || state_q == S_REFILL)) pend_d = 1'b1;

        if (rst) begin
            cache_ready = 1'b0;
            cache_valid = 1'b0;
            inst_data   = '0;
            data_we     = 1'b0;
            tag_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            resp_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            resp_q  <= resp_d;
            valid_q <= valid_d;
        end
    end

    // Data and tag storage is not reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (data_we) data_q[{idx, cnt_q}] <= mem_rdata;
        if (tag_we)  tag_q[idx]           <= tag;
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_req = 1'b0;
    logic [31:0] addr_inst = '0;
    logic        cache_ready;
    logic        cache_valid;
    logic [63:0] inst_data;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_rlast = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] B0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B1 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] C0 = 64'hAAAA_0000_AAAA_0000;
    localparam logic [63:0] C1 = 64'hBBBB_0001_BBBB_0001;
    localparam logic [63:0] D0 = 64'hD0D0_1234_D0D0_5678;
    localparam logic [63:0] D1 = 64'hD1D1_8765_D1D1_4321;
    localparam logic [63:0] E0 = 64'hE0E0_E0E0_0000_0001;
    localparam logic [63:0] E1 = 64'hE1E1_E1E1_0000_0002;

    icache_dm #(.ADDR_W(32), .INDEX_W(6), .LINE_BYTES(16)) dut (
        .clk(clk), .rst(rst),
        .cache_req(cache_req), .addr_inst(addr_inst),
        .cache_ready(cache_ready), .cache_valid(cache_valid), .inst_data(inst_data),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one request and acts as memory for a two-beat refill. Only records observations.
    task automatic req_miss(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                            input bit fl, output logic lk_vld, output logic [31:0] maddr,
                            output bit tmo, output bit rdy_hi, output bit vld_early,
                            output logic v_after, output logic [63:0] d_after,
                            output logic v_next, output logic r_next);
        int n;
        n = 0; tmo = 0; vld_early = 0; maddr = '0;
        v_after = 0; d_after = '0; v_next = 0; r_next = 0;
        cache_req = 1'b1; addr_inst = a;
        @(negedge clk);
        cache_req = 1'b0;
        lk_vld = cache_valid;
        rdy_hi = cache_ready;
        while (!mem_req) begin
            if (n >= 20) begin tmo = 1; return; end
            @(negedge clk); n++;
            if (cache_ready) rdy_hi = 1;
            if (cache_valid) vld_early = 1;
        end
        maddr = mem_addr;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        if (cache_ready) rdy_hi = 1;
        if (cache_valid) vld_early = 1;
        mem_rvalid = 1'b1; mem_rdata = b0; mem_rlast = 1'b0; flush = fl;
        @(negedge clk);
        flush = 1'b0;
        if (cache_ready) rdy_hi = 1;
        if (cache_valid) vld_early = 1;
        mem_rdata = b1; mem_rlast = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        v_after = cache_valid; d_after = inst_data;
        if (cache_ready) rdy_hi = 1;
        @(negedge clk);
        v_next = cache_valid; r_next = cache_ready;
    endtask

    task automatic req_hit(input logic [31:0] a, output logic v, output logic [63:0] d,
                           output logic mreq, output logic v2);
        cache_req = 1'b1; addr_inst = a;
        @(negedge clk);
        cache_req = 1'b0;
        v = cache_valid; d = inst_data;
        @(negedge clk);
        mreq = mem_req; v2 = cache_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cache_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cache_ready); end
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cache_valid); end
        checks++; if (inst_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", inst_data); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cache_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", cache_ready); end
    endtask

    task automatic test_cold_miss();
        logic lk, va, vn, rn; logic [31:0] ma; bit tmo, rh, ve; logic [63:0] d;
        req_miss(32'h8000_0004, B0, B1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL cold_timeout got %b want 0", tmo); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL cold_lookup_valid got %b want 0", lk); end
        checks++; if (ma !== 32'h8000_0000) begin errors++; $display("FAIL cold_mem_addr got %h want 80000000", ma); end
        checks++; if (rh !== 1'b0) begin errors++; $display("FAIL cold_ready_during_miss got %b want 0", rh); end
        checks++; if (ve !== 1'b0) begin errors++; $display("FAIL cold_early_valid got %b want 0", ve); end
        checks++; if (va !== 1'b1) begin errors++; $display("FAIL cold_resp_valid got %b want 1", va); end
        checks++; if (d !== B0) begin errors++; $display("FAIL cold_resp_data got %h want %h", d, B0); end
        checks++; if (vn !== 1'b0) begin errors++; $display("FAIL cold_single_pulse got %b want 0", vn); end
        checks++; if (rn !== 1'b1) begin errors++; $display("FAIL cold_ready_idle got %b want 1", rn); end
    endtask

    task automatic test_hit();
        logic v, mr, v2; logic [63:0] d;
        req_hit(32'h8000_0008, v, d, mr, v2);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL hit_valid got %b want 1", v); end
        checks++; if (d !== B1) begin errors++; $display("FAIL hit_data got %h want %h", d, B1); end
        checks++; if (mr !== 1'b0) begin errors++; $display("FAIL hit_mem_req got %b want 0", mr); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL hit_single_pulse got %b want 0", v2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [63:0] exp [3];
        addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0008; addrs[2] = 32'h8000_0000;
        exp[0] = B0; exp[1] = B1; exp[2] = B0;
        cache_req = 1'b1; addr_inst = addrs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (cache_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, cache_valid); end
            checks++; if (inst_data !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, inst_data, exp[i]); end
            checks++; if (cache_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, cache_ready); end
            if (i < 2) addr_inst = addrs[i+1];
            else cache_req = 1'b0;
        end
        @(negedge clk);
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", cache_valid); end
    endtask

    task automatic test_conflict();
        logic lk, va, vn, rn; logic [31:0] ma; bit tmo, rh, ve; logic [63:0] d;
        req_miss(32'h8000_0400, C0, C1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL conf_lookup_valid got %b want 0", lk); end
        checks++; if (ma !== 32'h8000_0400) begin errors++; $display("FAIL conf_mem_addr got %h want 80000400", ma); end
        checks++; if (d !== C0) begin errors++; $display("FAIL conf_data got %h want %h", d, C0); end
        req_miss(32'h8000_0000, B0, B1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL conf_remiss_timeout got %b want 0", tmo); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL conf_remiss_lookup got %b want 0", lk); end
        checks++; if (ma !== 32'h8000_0000) begin errors++; $display("FAIL conf_remiss_addr got %h want 80000000", ma); end
        checks++; if (d !== B0) begin errors++; $display("FAIL conf_remiss_data got %h want %h", d, B0); end
    endtask

    task automatic test_flush();
        logic lk, va, vn, rn, v, mr, v2; logic [31:0] ma; bit tmo, rh, ve; logic [63:0] d;
        // Flush while refilling line 1; word offset 1 is requested.
        req_miss(32'h8000_0018, D0, D1, 1, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (va !== 1'b1) begin errors++; $display("FAIL flr_resp_valid got %b want 1", va); end
        checks++; if (d !== D1) begin errors++; $display("FAIL flr_resp_data got %h want %h", d, D1); end
        checks++; if (rh !== 1'b0) begin errors++; $display("FAIL flr_ready_pending got %b want 0", rh); end
        checks++; if (rn !== 1'b1) begin errors++; $display("FAIL flr_ready_idle got %b want 1", rn); end
        req_miss(32'h8000_0018, D0, D1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL flr_refilled_misses got timeout %b want 0", tmo); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL flr_refilled_lookup got %b want 0", lk); end
        checks++; if (d !== D1) begin errors++; $display("FAIL flr_refill2_data got %h want %h", d, D1); end
        // Line 0 was valid before the flush; it must be gone too.
        req_miss(32'h8000_0000, B0, B1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL flr_other_line_lookup got %b want 0", lk); end
        checks++; if (ma !== 32'h8000_0000) begin errors++; $display("FAIL flr_other_line_addr got %h want 80000000", ma); end
        // Flush in IDLE.
        req_hit(32'h8000_0010, v, d, mr, v2);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL fli_prehit_valid got %b want 1", v); end
        checks++; if (d !== D0) begin errors++; $display("FAIL fli_prehit_data got %h want %h", d, D0); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_miss(32'h8000_0010, D0, D1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL fli_lookup got %b want 0", lk); end
        checks++; if (ma !== 32'h8000_0010) begin errors++; $display("FAIL fli_mem_addr got %h want 80000010", ma); end
        checks++; if (d !== D0) begin errors++; $display("FAIL fli_data got %h want %h", d, D0); end
    endtask

    task automatic test_reset_mid_refill();
        logic lk, va, vn, rn, v, mr, v2; logic [31:0] ma; bit tmo, rh, ve; logic [63:0] d;
        cache_req = 1'b1; addr_inst = 32'h8000_0020;
        @(negedge clk);
        cache_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmr_mem_req got %b want 1", mem_req); end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = E0; mem_rlast = 1'b0;
        @(negedge clk);
        rst = 1'b1; mem_rdata = E1; mem_rlast = 1'b1;
        @(negedge clk);
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid_in_reset got %b want 0", cache_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmr_mem_req_in_reset got %b want 0", mem_req); end
        checks++; if (cache_ready !== 1'b0) begin errors++; $display("FAIL rmr_ready_in_reset got %b want 0", cache_ready); end
        rst = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL rmr_stray_valid got %b want 0", cache_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmr_stray_mem_req got %b want 0", mem_req); end
        checks++; if (cache_ready !== 1'b1) begin errors++; $display("FAIL rmr_ready_after got %b want 1", cache_ready); end
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        // Reset cleared all valid bits, including line 1 filled earlier.
        req_miss(32'h8000_0010, D0, D1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL rmr_cleared_lookup got %b want 0", lk); end
        req_miss(32'h8000_0020, E0, E1, 0, lk, ma, tmo, rh, ve, va, d, vn, rn);
        checks++; if (ma !== 32'h8000_0020) begin errors++; $display("FAIL rmr_refill_addr got %h want 80000020", ma); end
        checks++; if (va !== 1'b1) begin errors++; $display("FAIL rmr_refill_valid got %b want 1", va); end
        checks++; if (d !== E0) begin errors++; $display("FAIL rmr_refill_data got %h want %h", d, E0); end
        req_hit(32'h8000_0028, v, d, mr, v2);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL rmr_hit_valid got %b want 1", v); end
        checks++; if (d !== E1) begin errors++; $display("FAIL rmr_hit_data got %h want %h", d, E1); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
